// File: rtl/operand_forward_unit.sv
// EX-stage operand forwarding: MEM > WB > regfile per source, load-use stall FSM, and
// per-source hold registers for externally stalled EX. FWD_PERF_CNT_EN adds perf counters.
module operand_forward_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_valid,
  input  logic                           ex_stall_in,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  ex_rs_addr,
  input  logic [NUM_SRC*DATA_W-1:0]      ex_rs_data,
  input  logic                           mem_reg_write,
  input  logic                           mem_mem_read,
  input  logic [REG_ADDR_W-1:0]          mem_rd_addr,
  input  logic [DATA_W-1:0]              mem_alu_result,
  input  logic                           wb_reg_write,
  input  logic [REG_ADDR_W-1:0]          wb_rd_addr,
  input  logic [DATA_W-1:0]              wb_write_data,
  output logic [NUM_SRC*DATA_W-1:0]      fwd_data_out,
  output logic [NUM_SRC*2-1:0]           fwd_sel_out,
  output logic                           load_use_stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_lu_stalls,
  output logic [31:0]                    perf_fwd_events
`endif
);

  localparam logic [1:0] SelRf   = 2'b00;
  localparam logic [1:0] SelWb   = 2'b01;
  localparam logic [1:0] SelMem  = 2'b10;
  localparam logic [1:0] SelHold = 2'b11;

  typedef enum logic [0:0] {StRun, StLuStall} state_e;

  state_e state_q, state_d;

  logic [NUM_SRC-1:0] lu_hit;
  logic [NUM_SRC-1:0] fwd_used;  // source selects MEM or WB this cycle
  logic               hazard;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  mem_hit;
    logic                  wb_hit;
    logic [1:0]            sel;
    logic [DATA_W-1:0]     data;
    logic                  hold_valid_q;
    logic [DATA_W-1:0]     hold_data_q;

    assign rs      = ex_rs_addr[i*REG_ADDR_W +: REG_ADDR_W];
    assign mem_hit = mem_reg_write && (mem_rd_addr == rs) && (rs != '0);
    assign wb_hit  = wb_reg_write && (wb_rd_addr == rs) && (rs != '0);
    assign lu_hit[i] = ex_valid && mem_hit && mem_mem_read;

    always_comb begin
      sel  = SelRf;
      data = ex_rs_data[i*DATA_W +: DATA_W];
      if (hold_valid_q) begin
        sel  = SelHold;
        data = hold_data_q;
      end else if (mem_hit && !mem_mem_read) begin
        sel  = SelMem;
        data = mem_alu_result;
      end else if (wb_hit) begin
        sel  = SelWb;
        data = wb_write_data;
      end
    end

    assign fwd_used[i] = (sel == SelMem) || (sel == SelWb);
    assign fwd_sel_out[2*i +: 2]           = sel;
    assign fwd_data_out[i*DATA_W +: DATA_W] = data;

    // Capture only bypassed values; regfile operands stay put in ID/EX during the stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_valid_q <= 1'b0;
        hold_data_q  <= '0;
      end else if (!ex_stall_in) begin
        hold_valid_q <= 1'b0;
      end else if (ex_valid && !hold_valid_q && !lu_hit[i] && fwd_used[i]) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= data;
      end
    end
  end

  assign hazard = |lu_hit;

  always_comb begin
    state_d        = state_q;
    load_use_stall = 1'b0;
    case (state_q)
      StRun: begin
        if (hazard && !ex_stall_in) begin
          load_use_stall = 1'b1;
          state_d        = StLuStall;
        end
      end
      StLuStall: state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] lu_cnt_q;
  logic [31:0] fwd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_cnt_q  <= '0;
      fwd_cnt_q <= '0;
    end else begin
      if (load_use_stall && (lu_cnt_q != '1)) begin
        lu_cnt_q <= lu_cnt_q + 32'd1;
      end
      if (ex_valid && (|fwd_used) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + 32'd1;
      end
    end
  end

  assign perf_lu_stalls  = lu_cnt_q;
  assign perf_fwd_events = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed scenarios, then random traffic checked against a
// behavioural model of the forwarding, load-use and hold rules.
module tb_operand_forward_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid, ex_stall_in;
  logic [NS*AW-1:0] ex_rs_addr;
  logic [NS*DW-1:0] ex_rs_data;
  logic             mem_reg_write, mem_mem_read;
  logic [AW-1:0]    mem_rd_addr;
  logic [DW-1:0]    mem_alu_result;
  logic             wb_reg_write;
  logic [AW-1:0]    wb_rd_addr;
  logic [DW-1:0]    wb_write_data;
  logic [NS*DW-1:0] fwd_data_out;
  logic [NS*2-1:0]  fwd_sel_out;
  logic             load_use_stall;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]      perf_lu_stalls, perf_fwd_events;
`endif

  operand_forward_unit #(.DATA_W(DW), .REG_ADDR_W(AW), .NUM_SRC(NS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_stall_in    (ex_stall_in),
    .ex_rs_addr     (ex_rs_addr),
    .ex_rs_data     (ex_rs_data),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_read   (mem_mem_read),
    .mem_rd_addr    (mem_rd_addr),
    .mem_alu_result (mem_alu_result),
    .wb_reg_write   (wb_reg_write),
    .wb_rd_addr     (wb_rd_addr),
    .wb_write_data  (wb_write_data),
    .fwd_data_out   (fwd_data_out),
    .fwd_sel_out    (fwd_sel_out),
    .load_use_stall (load_use_stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .perf_lu_stalls (perf_lu_stalls),
    .perf_fwd_events(perf_fwd_events)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pending hold values, whether last cycle was a load-use stall, counters.
  bit          m_hold_v [NS];
  logic [DW-1:0] m_hold_d [NS];
  bit          m_in_lu;
  longint      m_lu_cnt, m_fwd_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_hold_v[i] = 1'b0;
      m_hold_d[i] = '0;
    end
    m_in_lu   = 1'b0;
    m_lu_cnt  = 0;
    m_fwd_cnt = 0;
  endtask

  // Compare DUT against the reference for the current inputs, then advance past the next edge.
  task automatic model_step();
    logic [NS*2-1:0]  e_sel;
    logic [NS*DW-1:0] e_data;
    int               s [NS];
    bit               lu [NS];
    bit               hazard, any_fwd, e_stall;
    hazard  = 1'b0;
    any_fwd = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int          rs;
      bit          mh, wh;
      logic [DW-1:0] d;
      rs = int'(ex_rs_addr[i*AW +: AW]);
      mh = mem_reg_write && rs != 0 && int'(mem_rd_addr) == rs;
      wh = wb_reg_write && rs != 0 && int'(wb_rd_addr) == rs;
      lu[i] = ex_valid && mh && mem_mem_read;
      if (m_hold_v[i])            begin s[i] = 3; d = m_hold_d[i]; end
      else if (mh && !mem_mem_read) begin s[i] = 2; d = mem_alu_result; end
      else if (wh)                begin s[i] = 1; d = wb_write_data; end
      else                        begin s[i] = 0; d = ex_rs_data[i*DW +: DW]; end
      e_sel[i*2 +: 2]   = 2'(s[i]);
      e_data[i*DW +: DW] = d;
      hazard  = hazard | lu[i];
      any_fwd = any_fwd | (s[i] == 1 || s[i] == 2);
    end
    e_stall = !m_in_lu && hazard && !ex_stall_in;
    check_eq("sel", 64'(fwd_sel_out), 64'(e_sel));
    check_eq("data", 64'(fwd_data_out), 64'(e_data));
    check_eq("stall", 64'(load_use_stall), 64'(e_stall));
`ifdef FWD_PERF_CNT_EN
    check_eq("perf_lu", 64'(perf_lu_stalls), 64'(m_lu_cnt));
    check_eq("perf_fwd", 64'(perf_fwd_events), 64'(m_fwd_cnt));
`endif
    for (int i = 0; i < NS; i++) begin
      if (!ex_stall_in) m_hold_v[i] = 1'b0;
      else if (ex_valid && !m_hold_v[i] && !lu[i] && (s[i] == 1 || s[i] == 2)) begin
        m_hold_v[i] = 1'b1;
        m_hold_d[i] = e_data[i*DW +: DW];
      end
    end
    if (e_stall) m_lu_cnt = (m_lu_cnt < 64'hFFFF_FFFF) ? m_lu_cnt + 1 : m_lu_cnt;
    if (ex_valid && any_fwd) m_fwd_cnt = (m_fwd_cnt < 64'hFFFF_FFFF) ? m_fwd_cnt + 1 : m_fwd_cnt;
    m_in_lu = e_stall;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input bit st, input int rs0, input int rs1,
                        input bit mw, input bit mr, input int mrd, input logic [DW-1:0] md,
                        input bit ww, input int wrd, input logic [DW-1:0] wd);
    ex_valid       = v;
    ex_stall_in    = st;
    ex_rs_addr     = {AW'(rs1), AW'(rs0)};
    mem_reg_write  = mw;
    mem_mem_read   = mr;
    mem_rd_addr    = AW'(mrd);
    mem_alu_result = md;
    wb_reg_write   = ww;
    wb_rd_addr     = AW'(wrd);
    wb_write_data  = wd;
  endtask

  initial begin
    rst_n      = 1'b0;
    ex_rs_data = {32'hC1C1_C1C1, 32'hC0C0_C0C0};
    set_in(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
    model_reset();
    #2;
    check_eq("rst_stall", 64'(load_use_stall), 64'd0);
    check_eq("rst_sel", 64'(fwd_sel_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // MEM add $3, WB sub $4
    set_in(1, 0, 3, 4, 1, 0, 3, 32'h11, 1, 4, 32'h22);
    #4;
    check_eq("d_fwd_sel", 64'(fwd_sel_out), 64'(4'b0110));
    check_eq("d_fwd_data", 64'(fwd_data_out), {32'h22, 32'h11});
    model_step();

    // MEM beats WB; $0 never forwarded
    set_in(1, 0, 5, 0, 1, 0, 5, 32'hAA, 1, 5, 32'hBB);
    #4;
    check_eq("d_prio_data", 64'(fwd_data_out), {32'hC1C1_C1C1, 32'hAA});
    model_step();
    set_in(1, 0, 0, 0, 1, 0, 0, 32'h77, 1, 0, 32'h78);
    #4;
    check_eq("d_r0_sel", 64'(fwd_sel_out), 64'd0);
    model_step();

    // lw $6 then dependent use
    set_in(1, 0, 6, 0, 1, 1, 6, 32'h400, 0, 0, '0);
    #4;
    check_eq("d_lu_stall", 64'(load_use_stall), 64'd1);
    model_step();
    set_in(1, 0, 6, 0, 0, 0, 0, '0, 1, 6, 32'h1234);
    #4;
    check_eq("d_lu_wb_sel", 64'(fwd_sel_out), 64'(4'b0001));
    check_eq("d_lu_wb_stall", 64'(load_use_stall), 64'd0);
    model_step();

    // External stall: $7 drains MEM -> WB -> retired while held
    set_in(1, 1, 7, 0, 1, 0, 7, 32'h55, 0, 0, '0);
    #4; model_step();
    set_in(1, 1, 7, 0, 0, 0, 0, '0, 1, 7, 32'h55);
    #4;
    check_eq("d_hold2_sel", 64'(fwd_sel_out), 64'(4'b0011));
    model_step();
    set_in(1, 1, 7, 0, 0, 0, 0, '0, 0, 0, '0);
    #4;
    check_eq("d_hold3_data", 64'(fwd_data_out[DW-1:0]), 64'h55);
    model_step();
    set_in(1, 0, 7, 0, 0, 0, 0, '0, 0, 0, '0);
    #4;
    check_eq("d_release_sel", 64'(fwd_sel_out), 64'(4'b0011));
    model_step();
    #4;
    check_eq("d_after_sel", 64'(fwd_sel_out), 64'd0);
    model_step();

    // Reset mid-hold
    set_in(1, 1, 7, 0, 1, 0, 7, 32'h55, 0, 0, '0);
    #4; model_step();
    set_in(1, 1, 7, 0, 0, 0, 0, '0, 1, 7, 32'h66);
    #1;
    check_eq("d_prerst_sel", 64'(fwd_sel_out), 64'(4'b0011));
    rst_n = 1'b0;
    #1;
    check_eq("d_rst_sel", 64'(fwd_sel_out), 64'(4'b0001));
    check_eq("d_rst_data", 64'(fwd_data_out[DW-1:0]), 64'h66);
    model_reset();
    rst_n = 1'b1;
    #2; model_step();

    // Random traffic on a small register window so hits are frequent
    for (int n = 0; n < 600; n++) begin
      ex_rs_data = {$urandom(), $urandom()};
      set_in(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom(),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom());
      if ($urandom_range(0, 63) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        #3;
      end else begin
        #4;
      end
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_forward_unit.md
# operand_forward_unit

Parametrised EX-stage operand forwarding unit for the MIPS32 pipeline, the successor to the fixed two-way per-operand forwarding muxes. It resolves NUM_SRC source operands against the MEM and WB stages, priority MEM over WB over register file. It detects load-use hazards and issues a one-cycle stall request under a small FSM. During external EX stalls, per-source hold registers keep forwarded values that would otherwise drain out of MEM/WB.

## Interface
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands resolved in parallel (1..4)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_stall_in  in  1  EX held this cycle; MEM/WB keep draining (bubbles enter MEM)
- ex_rs_addr  in  NUM_SRC*REG_ADDR_W  source register numbers, source i at slice i
- ex_rs_data  in  NUM_SRC*DATA_W  register-file values from ID/EX
- mem_reg_write  in  1  MEM instruction writes a register
- mem_mem_read  in  1  MEM instruction is a load (ALU result is an address, not data)
- mem_rd_addr  in  REG_ADDR_W  MEM destination
- mem_alu_result  in  DATA_W  MEM forwardable value
- wb_reg_write  in  1  WB instruction writes a register
- wb_rd_addr  in  REG_ADDR_W  WB destination
- wb_write_data  in  DATA_W  WB value
- fwd_data_out  out  NUM_SRC*DATA_W  resolved operands (combinational)
- fwd_sel_out  out  NUM_SRC*2  per source: 00 regfile, 01 WB, 10 MEM, 11 hold register
- load_use_stall  out  1  request: freeze IF/ID, bubble into EX→MEM

## Operation
- Match rules per source i: mem_hit = mem_reg_write && mem_rd_addr==rs_i && rs_i!=0; wb_hit likewise with WB. Register 0 is never forwarded and always selects regfile.
- Select priority: hold_valid[i] → hold; else mem_hit && !mem_mem_read → MEM; else wb_hit → WB; else regfile.
- lu_hit[i] = ex_valid && mem_hit && mem_mem_read. hazard = OR over sources.
- FSM states RUN, LU_STALL. In RUN: load_use_stall = hazard && !ex_stall_in. RUN→LU_STALL on that condition. LU_STALL→RUN unconditionally next cycle. load_use_stall is 0 in LU_STALL, where the load is in WB and is forwarded from there.
- While lu_hit[i] (MEM is a load) and no WB match, source i falls to regfile; EX result that cycle is discarded by the stall.
- Hold registers: on a clock edge with ex_stall_in=1 and ex_valid=1, each source i with !hold_valid[i], !lu_hit[i] and select in {MEM, WB} captures the selected value; hold_valid[i] set. Regfile-selected sources are not captured (ID/EX holds them).
- On an edge with ex_stall_in=0, all hold_valid clear (hold used for the release cycle, then dropped).
- An externally stalled load-use case does not capture while lu_hit. The load reaches WB next cycle and is captured then.

## Timing
- Reset (async, rst_n low): state=RUN, hold_valid=0, hold data=0. load_use_stall=0. fwd_sel_out/fwd_data_out follow combinational inputs immediately with no hold.
- Forwarding latency zero: fwd_data_out valid in the same cycle as inputs.
- Load-use costs exactly one stall cycle per dependent instruction. Back-to-back dependent loads each get one.
- Hold data valid from the cycle after the first stall edge until the edge where ex_stall_in=0 is sampled.
- Reset asserted mid-stall drops hold and FSM state immediately.

## Configuration
- FWD_PERF_CNT_EN defined: adds outputs perf_lu_stalls[31:0] (increments on each RUN→LU_STALL) and perf_fwd_events[31:0]. perf_fwd_events increments by 1 per cycle where ex_valid and any source selects MEM or WB. Both counters saturate at 0xFFFFFFFF and reset to 0.
- Not defined: counters and ports absent; functional behaviour identical.

## Test plan
- add $3 in MEM (mem_alu_result=0x11), sub $4 in WB (0x22), EX reads rs0=$3, rs1=$4 → fwd_sel_out 10/01, data 0x11/0x22, no stall.
- MEM and WB both write $5 (0xAA/0xBB), EX reads $5 → MEM wins, 0xAA. EX reads $0 with MEM writing $0 → regfile value, sel 00.
- lw $6 in MEM, EX reads $6 → load_use_stall=1 one cycle. Next cycle load in WB with 0x1234 → sel 01, data 0x1234, stall 0.
- ex_stall_in high 3 cycles, EX reads $7 produced in MEM (0x55), which drains to WB then retires → sel 11, data 0x55 in cycles 2–3 and the release cycle. hold_valid cleared afterwards.
- rst_n pulsed low mid-hold → immediately sel reverts to matching/regfile, hold_valid=0, state RUN.
- With FWD_PERF_CNT_EN: two load-use hazards plus 5 forwarding cycles → perf_lu_stalls=2, perf_fwd_events=7 (stall-release WB forwards included).
